// File: rtl/key_event_scan.sv
// rtl/key_event_scan.sv - per-key synchroniser, debounce FSM, press/release/long/repeat pulses and sticky flags
module key_event_scan #(
  parameter int N_KEYS       = 2,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [N_KEYS-1:0]     key_n,
  output logic [N_KEYS-1:0]     key_state,
  output logic [N_KEYS-1:0]     key_press,
  output logic [N_KEYS-1:0]     key_release,
  output logic [N_KEYS-1:0]     key_long,
  output logic [N_KEYS-1:0]     key_repeat,
  input  logic [4*N_KEYS-1:0]   evt_clr,
  output logic [4*N_KEYS-1:0]   evt_flags
);

  localparam int CNT_M1  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int CNT_MAX = (CNT_M1 > REPEAT_CYC) ? CNT_M1 : REPEAT_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PRESS_DB   = 3'd1;
  localparam logic [2:0] S_HELD       = 3'd2;
  localparam logic [2:0] S_LONG       = 3'd3;
  localparam logic [2:0] S_RELEASE_DB = 3'd4;

  genvar k;
  generate
    for (k = 0; k < N_KEYS; k++) begin : g_key
      logic          sync1_q, sync2_q;
      logic [2:0]    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          was_long_q, was_long_d;
      logic          down_q, down_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;
      logic          long_q, long_d;
      logic          rep_q, rep_d;
      logic [3:0]    flags_q, flags_d;

      // Sync flops idle at 1 so a reset never looks like a press.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
        end else begin
          sync1_q <= key_n[k];
          sync2_q <= sync1_q;
        end
      end

      always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        was_long_d = was_long_q;
        down_d     = down_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        long_d     = 1'b0;
        rep_d      = 1'b0;
        case (state_q)
          S_IDLE: begin
            if (!sync2_q) state_d = S_PRESS_DB;
          end
          S_PRESS_DB: begin
            if (sync2_q) begin
              state_d = S_IDLE;
            end else if (cnt_q == DB_LAST) begin
              state_d = S_HELD;
              press_d = 1'b1;
              down_d  = 1'b1;
            end
          end
          S_HELD: begin
            if (sync2_q) begin
              state_d = S_RELEASE_DB;
            end else if (cnt_q == LONG_LAST) begin
              state_d    = S_LONG;
              long_d     = 1'b1;
              was_long_d = 1'b1;
            end
          end
          S_LONG: begin
            if (sync2_q) begin
              state_d = S_RELEASE_DB;
            end else if (REPEAT_CYC == 0) begin
              cnt_d = cnt_q;
            end else if (cnt_q == REP_LAST) begin
              rep_d = 1'b1;
              cnt_d = '0;
            end
          end
          S_RELEASE_DB: begin
            // A low sample here is a release bounce: resume the hold phase silently.
            if (!sync2_q) begin
              state_d = was_long_q ? S_LONG : S_HELD;
            end else if (cnt_q == DB_LAST) begin
              state_d    = S_IDLE;
              rel_d      = 1'b1;
              down_d     = 1'b0;
              was_long_d = 1'b0;
            end
          end
          default: begin
            state_d    = S_IDLE;
            down_d     = 1'b0;
            was_long_d = 1'b0;
          end
        endcase
        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
      end

      // Set has priority over clear so an event is never lost to a racing clear.
      always_comb begin
        flags_d = (flags_q & ~evt_clr[4*k +: 4]) | {rep_q, long_q, rel_q, press_q};
      end

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          was_long_q <= 1'b0;
          down_q     <= 1'b0;
          press_q    <= 1'b0;
          rel_q      <= 1'b0;
          long_q     <= 1'b0;
          rep_q      <= 1'b0;
          flags_q    <= 4'b0;
        end else begin
          state_q    <= state_d;
          cnt_q      <= cnt_d;
          was_long_q <= was_long_d;
          down_q     <= down_d;
          press_q    <= press_d;
          rel_q      <= rel_d;
          long_q     <= long_d;
          rep_q      <= rep_d;
          flags_q    <= flags_d;
        end
      end

      assign key_state[k]         = down_q;
      assign key_press[k]         = press_q;
      assign key_release[k]       = rel_q;
      assign key_long[k]          = long_q;
      assign key_repeat[k]        = rep_q;
      assign evt_flags[4*k +: 4]  = flags_q;
    end
  endgenerate

endmodule

// File: tb/tb_key_event_scan.sv
// tb/tb_key_event_scan.sv - directed and randomized checks of key_event_scan against a timestamp-based model
module tb_key_event_scan;
  localparam int NK = 2;
  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [NK-1:0]     key_n = '1;
  logic [NK-1:0]     key_state, key_press, key_release, key_long, key_repeat;
  logic [4*NK-1:0]   evt_clr = '0;
  logic [4*NK-1:0]   evt_flags;

  int checks = 0;
  int failures = 0;

  always #10 sys_clk = ~sys_clk;

  key_event_scan #(
    .N_KEYS(NK), .DEBOUNCE_CYC(DB), .LONG_CYC(LG), .REPEAT_CYC(RP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_n),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat),
    .evt_clr(evt_clr), .evt_flags(evt_flags)
  );

  // Model: debounced decisions from run lengths, long/repeat from timestamps.
  bit              h1 [NK];
  bit              h2 [NK];
  bit              lvl [NK];
  int              run [NK];
  bit              pressed [NK];
  bit              is_long [NK];
  int              ref_t [NK];
  int              t = 0;
  logic [NK-1:0]   e_state, e_press, e_rel, e_long, e_rep;
  logic [4*NK-1:0] e_flags;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      h1[k] = 1'b1; h2[k] = 1'b1; lvl[k] = 1'b1; run[k] = 0;
      pressed[k] = 1'b0; is_long[k] = 1'b0; ref_t[k] = 0;
    end
    e_state = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_flags = '0;
  endtask

  task automatic model_edge(input logic [NK-1:0] kn, input logic [4*NK-1:0] clr);
    logic [4*NK-1:0] set;
    bit s;
    for (int k = 0; k < NK; k++)
      set[4*k +: 4] = {e_rep[k], e_long[k], e_rel[k], e_press[k]};
    e_flags = (e_flags & ~clr) | set;
    t++;
    for (int k = 0; k < NK; k++) begin
      s = h2[k];
      e_press[k] = 1'b0; e_rel[k] = 1'b0; e_long[k] = 1'b0; e_rep[k] = 1'b0;
      if (s == lvl[k]) run[k]++;
      else begin run[k] = 1; lvl[k] = s; end
      if (!pressed[k]) begin
        if (!s && run[k] == DB + 1) begin e_press[k] = 1'b1; pressed[k] = 1'b1; ref_t[k] = t; end
      end else if (s) begin
        if (run[k] == DB + 1) begin e_rel[k] = 1'b1; pressed[k] = 1'b0; is_long[k] = 1'b0; end
      end else if (run[k] == 1) begin
        ref_t[k] = t;
      end else if (!is_long[k]) begin
        if (t - ref_t[k] == LG) begin e_long[k] = 1'b1; is_long[k] = 1'b1; ref_t[k] = t; end
      end else if (RP != 0 && (t - ref_t[k]) % RP == 0) begin
        e_rep[k] = 1'b1;
      end
      h2[k] = h1[k];
      h1[k] = kn[k];
      e_state[k] = pressed[k];
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge(key_n, evt_clr);
    #1;
    check_eq("key_state", key_state, e_state);
    check_eq("key_press", key_press, e_press);
    check_eq("key_release", key_release, e_rel);
    check_eq("key_long", key_long, e_long);
    check_eq("key_repeat", key_repeat, e_rep);
    check_eq("evt_flags", evt_flags, e_flags);
  endtask

  int first, g, h, off, n1, n2, n3, p_off, l_off, r_off, seg [NK];

  initial begin
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check_eq("reset_outputs", {key_state, key_press, key_release, key_long, key_repeat, evt_flags}, 0);
    sys_rst_n = 1'b1;
    repeat (3) step();

    // 1: clean press latency and flag
    key_n[0] = 1'b0; first = t + 1; n1 = 0; p_off = -1;
    repeat (10) begin
      step();
      if (key_press[0]) begin n1++; p_off = t - first; end
    end
    check_eq("t1_press_offset", p_off, 6);
    check_eq("t1_press_count", n1, 1);
    check_eq("t1_flag", evt_flags[0], 1'b1);
    key_n[0] = 1'b1;
    repeat (10) step();

    // 2: bounce shorter than debounce
    key_n[0] = 1'b0;
    repeat (3) step();
    key_n[0] = 1'b1; n1 = 0;
    repeat (12) begin
      step();
      if (key_press[0] || key_state[0]) n1++;
    end
    check_eq("t2_no_press", n1, 0);

    // 3: long press then repeats
    key_n[0] = 1'b0; first = t + 1; n1 = 0; n2 = 0; l_off = -1;
    while (t < first + 50) begin
      step();
      off = t - first;
      if (key_long[0]) begin n1++; l_off = off; end
      if (key_repeat[0] && off > 26) n2++;
    end
    check_eq("t3_long_offset", l_off, 26);
    check_eq("t3_long_count", n1, 1);
    check_eq("t3_repeats", n2, 3);

    // 4: release glitch while long-held, then real release
    key_n[0] = 1'b1; g = t + 1;
    repeat (2) step();
    key_n[0] = 1'b0; n1 = 0; r_off = -1;
    while (t < g + 14) begin
      step();
      if (key_release[0]) n1++;
      if (key_repeat[0] && r_off < 0) r_off = t - g;
    end
    check_eq("t4_no_release", n1, 0);
    check_eq("t4_repeat_resume", r_off, 12);
    key_n[0] = 1'b1; h = t + 1; r_off = -1;
    repeat (10) begin
      step();
      if (key_release[0]) r_off = t - h;
    end
    check_eq("t4_release_offset", r_off, 6);
    check_eq("t4_state_low", key_state[0], 1'b0);

    // 5: simultaneous presses on both keys
    evt_clr = '1; step(); evt_clr = '0;
    key_n = '0; n1 = 0; n2 = 0;
    repeat (10) begin
      step();
      if (key_press == 2'b11) n1++;
      else if (key_press != 2'b00) n2++;
    end
    check_eq("t5_both_press", n1, 1);
    check_eq("t5_split_press", n2, 0);
    check_eq("t5_flags", evt_flags, 8'b0001_0001);
    key_n = '1;
    repeat (10) step();

    // 6: set beats clear, clear alone, async reset mid-debounce
    evt_clr = '1; step(); evt_clr = '0;
    key_n[0] = 1'b0;
    for (int i = 0; i < 12 && !key_press[0]; i++) step();
    check_eq("t6_press_seen", key_press[0], 1'b1);
    evt_clr = 8'h01; step();
    check_eq("t6_set_wins", evt_flags[0], 1'b1);
    step(); evt_clr = '0;
    check_eq("t6_clear", evt_flags[0], 1'b0);
    key_n[0] = 1'b1;
    repeat (10) step();
    key_n[0] = 1'b0;
    repeat (4) step();
    #3 sys_rst_n = 1'b0;
    #1;
    check_eq("t6_async_reset", {key_state, key_press, key_release, key_long, key_repeat, evt_flags}, 0);
    model_reset();
    key_n = '1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    n1 = 0;
    repeat (20) begin
      step();
      if ({key_press, key_release, key_long, key_repeat} != 0) n1++;
    end
    check_eq("t6_no_event_after_reset", n1, 0);

    // Randomized key activity with bounces, long holds and random clears
    for (int k = 0; k < NK; k++) seg[k] = $urandom_range(1, 30);
    repeat (4000) begin
      for (int k = 0; k < NK; k++) begin
        seg[k]--;
        if (seg[k] <= 0) begin
          key_n[k] = ~key_n[k];
          seg[k] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 70);
        end
      end
      evt_clr = ($urandom_range(0, 7) == 0) ? (4*NK)'($urandom) : '0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_event_scan.md
Name: key_event_scan

Overview:
- Conditions the raw push-button inputs (key2 and further board keys) before they reach the CPU PIO input byte (pio1in).
- Synchronises and debounces each key.
- Generates one-cycle press, release, long-press and auto-repeat pulses.
- Holds sticky event flags that firmware reads over PIO and clears per bit.
- Runs in the 50 MHz sys_clk domain.

Parameters:
- N_KEYS, 2, number of independent keys (1..4).
- DEBOUNCE_CYC, 1000000, stable-level cycles required to accept a press or release (20 ms @ 50 MHz); minimum 2.
- LONG_CYC, 50000000, held cycles after an accepted press before the long-press event (1 s); must be greater than DEBOUNCE_CYC.
- REPEAT_CYC, 10000000, interval between repeat pulses while long-held; 0 disables repeat.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- key_n  in  N_KEYS  raw key inputs, active-low (0 = pressed), asynchronous.
- key_state  out  N_KEYS  debounced level, 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse on an accepted press.
- key_release  out  N_KEYS  one-cycle pulse on an accepted release.
- key_long  out  N_KEYS  one-cycle pulse when the long-press threshold is reached.
- key_repeat  out  N_KEYS  one-cycle pulse every REPEAT_CYC while long-held.
- evt_clr  in  4*N_KEYS  per-bit clear strobe for evt_flags.
- evt_flags  out  4*N_KEYS  sticky flags; bit group k*4+{0,1,2,3} = {press, release, long, repeat} of key k.

Behaviour:
- Reset: every output is 0, sync flops are 1 (released), FSMs are in IDLE, counters are 0, was_long is 0. Reset is asserted asynchronously and takes effect immediately mid-debounce or mid-hold.
- Per key, key_n passes through a 2-FF synchroniser; the FSM uses the synchronised level only.
- One counter per key, wide enough for max(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)-1. The counter is cleared on every state transition.
- FSM states and transitions:
  - IDLE: key_state=0. If sync is low → PRESS_DB.
  - PRESS_DB: if sync goes high → IDLE, with no event (bounce rejected). Otherwise the counter increments. When counter==DEBOUNCE_CYC-1 → HELD, with key_press pulsed and key_state set to 1 in the same registered cycle.
  - HELD: if sync goes high → RELEASE_DB. Otherwise the counter increments. When counter==LONG_CYC-1 → LONG, with key_long pulsed and was_long=1.
  - LONG: if sync goes high → RELEASE_DB. Otherwise, if REPEAT_CYC≠0, the counter increments. When counter==REPEAT_CYC-1, key_repeat is pulsed and the counter returns to 0.
  - RELEASE_DB: key_state stays 1. If sync goes low → HELD if was_long=0, else LONG. This is a release bounce; the counter restarts and no event is emitted. Otherwise the counter increments. When counter==DEBOUNCE_CYC-1 → IDLE, with key_release pulsed, key_state=0 and was_long=0.
- Latency: key_press rises on the (DEBOUNCE_CYC+2)th rising edge after the first edge that samples key_n low, provided key_n stays low throughout. key_release follows the same rule for high.
- Each event output is registered and high for exactly 1 cycle. No two events of one key occur in the same cycle.
- evt_flags: a bit is set by its event pulse and cleared by its evt_clr bit. Set and clear in the same cycle → set wins. evt_clr on a bit that is already 0 has no effect.
- Keys are fully independent; simultaneous events on different keys are all reported.
- The synchroniser and the FSM must never produce X on any output.

Test Plan (DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8, N_KEYS=2):
1. Reset, then key_n[0] held low → key_press[0] is a single pulse on the 6th edge after the first low sample. key_state[0]=1 from the same cycle. evt_flags[0]=1.
2. key_n[0] low for 3 cycles, then high → no key_press. key_state stays 0. FSM returns to IDLE.
3. Held low for 6+20 edges → key_long[0] pulses once. Continued hold → key_repeat[0] every 8 cycles. Three repeats are counted over 24 further cycles.
4. While long-held: 2-cycle high glitch, then low → no release; repeats resume 8 cycles after re-entry to LONG. Then sustained high → key_release[0] on the 6th edge. key_state returns to 0.
5. Keys 0 and 1 pressed on the same edge → both key_press pulses in the same cycle. evt_flags=8'b0001_0001.
6. Pulse evt_clr[0] in the same cycle as a new key_press[0] → flag stays 1. evt_clr[0] alone next cycle → flag clears. Assert sys_rst_n low mid-PRESS_DB → all outputs 0 immediately, with no event after release.
